// File: rtl/axi_pkg.sv
// Shared AXI read-side encodings and the read arbiter state type.
package axi_pkg;

   // AXI burst type encodings
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // AXI beat size encodings (bytes per beat = 2**size)
   localparam logic [2:0] SIZE_1B   = 3'd0;
   localparam logic [2:0] SIZE_2B   = 3'd1;
   localparam logic [2:0] SIZE_4B   = 3'd2;
   localparam logic [2:0] SIZE_8B   = 3'd3;
   localparam logic [2:0] SIZE_16B  = 3'd4;
   localparam logic [2:0] SIZE_32B  = 3'd5;
   localparam logic [2:0] SIZE_64B  = 3'd6;
   localparam logic [2:0] SIZE_128B = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_arb_state_t;

   // Beat counter increment that sticks at 255 instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] i_v);
      return (i_v == 8'hFF) ? i_v : i_v + 8'd1;
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read channel (AR + R) bundle. "master" is the side issuing reads,
// "slave" is the side answering them.
interface axi_rd_arbiter_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the favoured requester;
// a lone requester always wins. On update the pointer moves to the master
// that was not just served.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   logic r_ptr;

   // Pointer starts favouring M1 and flips to the other master after service
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 1'b1;
      end else if (i_upd) begin
         r_ptr <= ~i_last;
      end
   end

   // Favoured requester wins a tie, otherwise whichever one is asking
   always_comb begin
      o_gnt = 2'b00;
      if (r_ptr) begin
         if (i_req[1])      o_gnt = 2'b10;
         else if (i_req[0]) o_gnt = 2'b01;
      end else begin
         if (i_req[0])      o_gnt = 2'b01;
         else if (i_req[1]) o_gnt = 2'b10;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read channel between the icache (M0) and dcache (M1)
// refill masters, one transaction outstanding at a time. AR fields are
// registered toward the downstream port; R beats are routed to the latched
// grant until rlast.
module axi_rd_arbiter
   import axi_pkg::*;
#(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   axi_rd_arbiter_if.slave  m0,
   axi_rd_arbiter_if.slave  m1,
   axi_rd_arbiter_if.master s,
   output logic             o_busy,
   output logic             o_len_err
);

   rd_arb_state_t     r_state;
   logic              r_gidx;
   logic [ID_W-1:0]   r_arid;
   logic [ADDR_W-1:0] r_araddr;
   logic [7:0]        r_arlen;
   logic [2:0]        r_arsize;
   logic [1:0]        r_arburst;
   logic              r_arvalid;
   logic [7:0]        r_cnt;
   logic              r_len_err;

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_s_rready;
   logic              w_beat;
   logic              w_upd;
   logic [8:0]        w_cnt_inc;
   logic [8:0]        w_beats_exp;

   assign w_req       = {m1.arvalid, m0.arvalid};
   assign w_s_rready  = (r_state == ST_DATA) && (r_gidx ? m1.rready : m0.rready);
   assign w_beat      = (r_state == ST_DATA) && s.rvalid && w_s_rready;
   assign w_upd       = w_beat && s.rlast;
   assign w_cnt_inc   = {1'b0, r_cnt} + 9'd1;
   assign w_beats_exp = {1'b0, r_arlen} + 9'd1;

   rr_arb2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .i_req  (w_req),
      .i_upd  (w_upd),
      .i_last (r_gidx),
      .o_gnt  (w_gnt)
   );

   // Transaction FSM: grant and latch AR, present AR downstream, route R until rlast
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gidx    <= 1'b0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
         r_arvalid <= 1'b0;
         r_cnt     <= '0;
         r_len_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_req) begin
                  r_gidx    <= w_gnt[1];
                  r_arid    <= w_gnt[1] ? m1.arid    : m0.arid;
                  r_araddr  <= w_gnt[1] ? m1.araddr  : m0.araddr;
                  r_arlen   <= w_gnt[1] ? m1.arlen   : m0.arlen;
                  r_arsize  <= w_gnt[1] ? m1.arsize  : m0.arsize;
                  r_arburst <= w_gnt[1] ? m1.arburst : m0.arburst;
                  r_arvalid <= 1'b1;
                  r_state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (r_arvalid && s.arready) begin
                  r_arvalid <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_beat) begin
                  r_cnt <= sat_inc8(r_cnt);
                  if (s.rlast) begin
                     r_state <= ST_IDLE;
                     if (w_cnt_inc != w_beats_exp) r_len_err <= 1'b1;
                  end else if (w_cnt_inc > w_beats_exp) begin
                     r_len_err <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Upstream AR accept: only in IDLE, only the granted master, never in reset
   assign m0.arready = !rst && (r_state == ST_IDLE) && w_gnt[0];
   assign m1.arready = !rst && (r_state == ST_IDLE) && w_gnt[1];

   // Downstream AR driven straight from the latched fields
   assign s.arid    = r_arid;
   assign s.araddr  = r_araddr;
   assign s.arlen   = r_arlen;
   assign s.arsize  = r_arsize;
   assign s.arburst = r_arburst;
   assign s.arvalid = r_arvalid;
   assign s.rready  = w_s_rready;

   // R payload fans out to both masters; only the granted one sees rvalid
   assign m0.rid    = s.rid;
   assign m0.rdata  = s.rdata;
   assign m0.rresp  = s.rresp;
   assign m0.rlast  = s.rlast;
   assign m0.rvalid = (r_state == ST_DATA) && !r_gidx && s.rvalid;
   assign m1.rid    = s.rid;
   assign m1.rdata  = s.rdata;
   assign m1.rresp  = s.rresp;
   assign m1.rlast  = s.rlast;
   assign m1.rvalid = (r_state == ST_DATA) && r_gidx && s.rvalid;

   assign o_busy    = (r_state != ST_IDLE);
   assign o_len_err = r_len_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: upstream requests and a downstream read slave are
// driven from one sequence; expected R beats go into a scoreboard queue when a
// transaction is set up and are popped as the granted master accepts them.
module tb_axi_rd_arbiter;
   import axi_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic o_busy;
   logic o_len_err;

   axi_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m0_if ();
   axi_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m1_if ();
   axi_rd_arbiter_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) s_if ();

   axi_rd_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .s         (s_if),
      .o_busy    (o_busy),
      .o_len_err (o_len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    n_chk = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [31:0] a, input int i);
      return (a + 32'(i * 4)) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [1:0] resp_of(input int i);
      return (i % 3 == 2) ? 2'b10 : 2'b00;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ar(input int mst, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
      if (mst == 1) begin
         m1_if.arid = id; m1_if.araddr = addr; m1_if.arlen = len;
         m1_if.arsize = SIZE_4B; m1_if.arburst = BURST_INCR; m1_if.arvalid = 1'b1;
      end else begin
         m0_if.arid = id; m0_if.araddr = addr; m0_if.arlen = len;
         m0_if.arsize = SIZE_4B; m0_if.arburst = BURST_INCR; m0_if.arvalid = 1'b1;
      end
   endtask

   task automatic push_exp(input logic [3:0] id, input logic [31:0] addr, input int nbeats);
      for (int i = 0; i < nbeats; i++)
         sb.push_back('{id: id, data: data_of(addr, i), resp: resp_of(i), last: (i == nbeats - 1)});
   endtask

   // Grant cycle check, then the registered AR on the following cycle
   task automatic grant(input int mst, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
      #1;
      chk("arready_win",  (mst == 1) ? m1_if.arready : m0_if.arready, 1);
      chk("arready_lose", (mst == 1) ? m0_if.arready : m1_if.arready, 0);
      tick();
      if (mst == 1) m1_if.arvalid = 1'b0; else m0_if.arvalid = 1'b0;
      #1;
      chk("s_arvalid", s_if.arvalid, 1);
      chk("s_araddr",  s_if.araddr, addr);
      chk("s_arid",    s_if.arid, id);
      chk("s_arlen",   s_if.arlen, len);
      chk("s_arsize",  s_if.arsize, SIZE_4B);
      chk("s_arburst", s_if.arburst, BURST_INCR);
      chk("busy_addr", o_busy, 1);
      chk("arready_addr", {m1_if.arready, m0_if.arready}, 0);
      tick();
   endtask

   task automatic do_addr(input int stall, input logic [31:0] addr);
      for (int k = 0; k < stall; k++) begin
         s_if.arready = 1'b0;
         #1;
         chk("stall_arvalid", s_if.arvalid, 1);
         chk("stall_araddr",  s_if.araddr, addr);
         chk("stall_arready", {m1_if.arready, m0_if.arready}, 0);
         tick();
      end
      s_if.arready = 1'b1;
      #1;
      chk("hs_arvalid", s_if.arvalid, 1);
      tick();
      s_if.arready = 1'b0;
   endtask

   // Downstream slave sends beats first..nbeats-1 (rlast on the final one),
   // returning early once beat index stop_at is reached (stop_at < 0: never)
   task automatic do_data(input int mst, input int nbeats, input int first, input int stop_at,
                          input logic [3:0] id, input logic [31:0] addr, input bit toggle);
      int    beat = first;
      int    cyc  = 0;
      beat_t e;
      logic  rdy;
      logic  g_rvalid, o_rvalid;
      logic [31:0] g_rdata;
      logic [3:0]  g_rid;
      logic [1:0]  g_rresp;
      logic        g_rlast;
      while (beat < nbeats && beat != stop_at) begin
         if (cyc > 4 * nbeats + 8) begin
            chk("data_timeout", 1, 0);
            break;
         end
         rdy = toggle ? logic'(cyc % 2) : 1'b1;
         s_if.rvalid = (cyc % 5 != 3);
         s_if.rid    = id;
         s_if.rdata  = data_of(addr, beat);
         s_if.rresp  = resp_of(beat);
         s_if.rlast  = (beat == nbeats - 1);
         if (mst == 1) begin m1_if.rready = rdy; m0_if.rready = 1'b1; end
         else          begin m0_if.rready = rdy; m1_if.rready = 1'b1; end
         #1;
         g_rvalid = (mst == 1) ? m1_if.rvalid : m0_if.rvalid;
         o_rvalid = (mst == 1) ? m0_if.rvalid : m1_if.rvalid;
         g_rdata  = (mst == 1) ? m1_if.rdata  : m0_if.rdata;
         g_rid    = (mst == 1) ? m1_if.rid    : m0_if.rid;
         g_rresp  = (mst == 1) ? m1_if.rresp  : m0_if.rresp;
         g_rlast  = (mst == 1) ? m1_if.rlast  : m0_if.rlast;
         chk("s_rready",     s_if.rready, rdy);
         chk("g_rvalid",     g_rvalid, s_if.rvalid);
         chk("other_rvalid", o_rvalid, 0);
         chk("arready_data", {m1_if.arready, m0_if.arready}, 0);
         if (s_if.rvalid && rdy) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rdata", g_rdata, e.data);
               chk("rid",   g_rid, e.id);
               chk("rresp", g_rresp, e.resp);
               chk("rlast", g_rlast, e.last);
            end
            beat++;
         end
         cyc++;
         tick();
      end
      s_if.rvalid = 1'b0;
      s_if.rlast  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0;
      m0_if.arburst = '0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
      m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0;
      m1_if.arburst = '0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
      s_if.arready = 1'b0; s_if.rid = '0; s_if.rdata = '0; s_if.rresp = '0;
      s_if.rlast = 1'b0; s_if.rvalid = 1'b0;
      repeat (3) tick();

      // Reset state, with a request pending that must not be accepted
      m0_if.arvalid = 1'b1;
      s_if.rvalid   = 1'b1;
      #1;
      chk("rst_busy",    o_busy, 0);
      chk("rst_arvalid", s_if.arvalid, 0);
      chk("rst_araddr",  s_if.araddr, 0);
      chk("rst_arlen",   s_if.arlen, 0);
      chk("rst_arready", {m1_if.arready, m0_if.arready}, 0);
      chk("rst_rvalid",  {m1_if.rvalid, m0_if.rvalid}, 0);
      chk("rst_rready",  s_if.rready, 0);
      chk("rst_len_err", o_len_err, 0);
      m0_if.arvalid = 1'b0;
      s_if.rvalid   = 1'b0;
      rst = 1'b0;
      tick();

      // Single M0 8-beat refill from the boot vector
      set_ar(0, 4'h3, 32'h1fc0_0000, 8'd7);
      grant(0, 4'h3, 32'h1fc0_0000, 8'd7);
      push_exp(4'h3, 32'h1fc0_0000, 8);
      do_addr(0, 32'h1fc0_0000);
      do_data(0, 8, 0, -1, 4'h3, 32'h1fc0_0000, 1'b0);
      chk("t1_sb_empty", sb.size(), 0);
      chk("t1_busy",     o_busy, 0);
      chk("t1_len_err",  o_len_err, 0);

      // Both request after reset: M1 first, M0 one cycle after M1's rlast
      do_reset();
      set_ar(0, 4'h1, 32'h0000_1000, 8'd3);
      set_ar(1, 4'h2, 32'h0000_2000, 8'd3);
      grant(1, 4'h2, 32'h0000_2000, 8'd3);
      push_exp(4'h2, 32'h0000_2000, 4);
      do_addr(0, 32'h0000_2000);
      do_data(1, 4, 0, -1, 4'h2, 32'h0000_2000, 1'b0);
      grant(0, 4'h1, 32'h0000_1000, 8'd3);
      push_exp(4'h1, 32'h0000_1000, 4);
      do_addr(0, 32'h0000_1000);
      do_data(0, 4, 0, -1, 4'h1, 32'h0000_1000, 1'b0);
      chk("t2_sb_empty", sb.size(), 0);

      // M1 alone, then both again: M0 wins the tie, with a 5-cycle AR stall
      set_ar(1, 4'h4, 32'h0000_3000, 8'd1);
      grant(1, 4'h4, 32'h0000_3000, 8'd1);
      push_exp(4'h4, 32'h0000_3000, 2);
      do_addr(0, 32'h0000_3000);
      do_data(1, 2, 0, -1, 4'h4, 32'h0000_3000, 1'b0);
      set_ar(0, 4'h5, 32'h0000_4000, 8'd1);
      set_ar(1, 4'h6, 32'h0000_5000, 8'd1);
      grant(0, 4'h5, 32'h0000_4000, 8'd1);
      push_exp(4'h5, 32'h0000_4000, 2);
      do_addr(5, 32'h0000_4000);
      do_data(0, 2, 0, -1, 4'h5, 32'h0000_4000, 1'b0);
      grant(1, 4'h6, 32'h0000_5000, 8'd1);
      push_exp(4'h6, 32'h0000_5000, 2);
      do_addr(0, 32'h0000_5000);
      do_data(1, 2, 0, -1, 4'h6, 32'h0000_5000, 1'b0);
      chk("t3_sb_empty", sb.size(), 0);

      // M0 rready toggling through an 8-beat burst
      set_ar(0, 4'h7, 32'h0000_6000, 8'd7);
      grant(0, 4'h7, 32'h0000_6000, 8'd7);
      push_exp(4'h7, 32'h0000_6000, 8);
      do_addr(0, 32'h0000_6000);
      do_data(0, 8, 0, -1, 4'h7, 32'h0000_6000, 1'b1);
      chk("t4_sb_empty", sb.size(), 0);
      chk("t4_len_err",  o_len_err, 0);

      // Early rlast on beat 4 of arlen=7, then a clean burst: error sticks
      set_ar(0, 4'h8, 32'h0000_7000, 8'd7);
      grant(0, 4'h8, 32'h0000_7000, 8'd7);
      push_exp(4'h8, 32'h0000_7000, 4);
      do_addr(0, 32'h0000_7000);
      do_data(0, 4, 0, -1, 4'h8, 32'h0000_7000, 1'b0);
      chk("t5_len_err", o_len_err, 1);
      chk("t5_busy",    o_busy, 0);
      set_ar(1, 4'h9, 32'h0000_8000, 8'd0);
      grant(1, 4'h9, 32'h0000_8000, 8'd0);
      push_exp(4'h9, 32'h0000_8000, 1);
      do_addr(0, 32'h0000_8000);
      do_data(1, 1, 0, -1, 4'h9, 32'h0000_8000, 1'b0);
      chk("t5_len_err_sticky", o_len_err, 1);

      // Reset in the middle of a data burst
      set_ar(0, 4'hA, 32'h0000_9000, 8'd7);
      grant(0, 4'hA, 32'h0000_9000, 8'd7);
      push_exp(4'hA, 32'h0000_9000, 8);
      do_addr(0, 32'h0000_9000);
      do_data(0, 8, 0, 2, 4'hA, 32'h0000_9000, 1'b0);
      chk("t6_busy_pre", o_busy, 1);
      rst = 1'b1;
      tick();
      s_if.rvalid = 1'b1;
      m0_if.rready = 1'b1;
      #1;
      chk("t6_busy",    o_busy, 0);
      chk("t6_rready",  s_if.rready, 0);
      chk("t6_rvalid",  {m1_if.rvalid, m0_if.rvalid}, 0);
      chk("t6_len_err", o_len_err, 0);
      s_if.rvalid = 1'b0;
      sb.delete();
      rst = 1'b0;
      tick();

      // Overrun: arlen=1 but rlast only on beat 4; flagged on beat 3
      set_ar(1, 4'hB, 32'h0000_A000, 8'd1);
      grant(1, 4'hB, 32'h0000_A000, 8'd1);
      push_exp(4'hB, 32'h0000_A000, 4);
      do_addr(0, 32'h0000_A000);
      do_data(1, 4, 0, 2, 4'hB, 32'h0000_A000, 1'b0);
      chk("t7_len_err_b2", o_len_err, 0);
      do_data(1, 4, 2, 3, 4'hB, 32'h0000_A000, 1'b0);
      chk("t7_len_err_b3", o_len_err, 1);
      chk("t7_busy_b3",    o_busy, 1);
      do_data(1, 4, 3, -1, 4'hB, 32'h0000_A000, 1'b0);
      chk("t7_busy",     o_busy, 0);
      chk("t7_len_err",  o_len_err, 1);
      chk("t7_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
